// File: rtl/simulate1_wrapper_if.sv
// Host-side bus for simulate1_wrapper: the IMEM and DMEM byte command ports plus the run level.
// The wrapper connects to the slave modport; the host drives through the master modport.
interface simulate1_wrapper_if;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic [7:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       cmd_done;
    logic [7:0] cmd_data;
    logic       cmd_valid_data;
    logic [7:0] address_data;
    logic [7:0] data_in_data;
    logic [7:0] data_out_data;
    logic       cmd_done_data;
    logic       start_signal;

    modport master (
        output cmd, cmd_valid, address, data_in,
        output cmd_data, cmd_valid_data, address_data, data_in_data,
        output start_signal,
        input  data_out, cmd_done, data_out_data, cmd_done_data
    );

    modport slave (
        input  cmd, cmd_valid, address, data_in,
        input  cmd_data, cmd_valid_data, address_data, data_in_data,
        input  start_signal,
        output data_out, cmd_done, data_out_data, cmd_done_data
    );
endinterface

// File: rtl/simulate1_wrapper.sv
// RV32I-subset harness: byte-loadable big-endian IMEM/DMEM and a two-cycle-per-instruction core.
// Optional feature macro SIM1_REGREAD_EN: DMEM port command 3 reads the low byte of a core register.
module simulate1_wrapper #(
    parameter int MEM_BYTES = 64
) (
    input  logic                clk,
    input  logic                rst,
    simulate1_wrapper_if.slave  bus
);

    localparam int AW = $clog2(MEM_BYTES);

    localparam logic [6:0] OPC_OPIMM = 7'h13;
    localparam logic [6:0] OPC_OP    = 7'h33;
    localparam logic [6:0] OPC_LUI   = 7'h37;
    localparam logic [6:0] OPC_AUIPC = 7'h17;
    localparam logic [6:0] OPC_LOAD  = 7'h03;
    localparam logic [6:0] OPC_STORE = 7'h23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    logic [7:0]    imem_r [0:MEM_BYTES-1];
    logic [7:0]    dmem_r [0:MEM_BYTES-1];
    logic [31:0]   regs_r [0:31];
    logic [31:0]   pc_r;
    logic [31:0]   ir_r;
    state_t        state_r;

    logic          cmd_valid_q_r;
    logic          cmd_valid_data_q_r;
    logic [7:0]    data_out_r;
    logic          cmd_done_r;
    logic [7:0]    data_out_data_r;
    logic          cmd_done_data_r;

    logic          imem_acc_s;
    logic          dmem_acc_s;
    logic [AW-1:0] pa0_s, pa1_s, pa2_s, pa3_s;
    logic [31:0]   fetch_word_s;

    logic [6:0]    opcode_s;
    logic [4:0]    rd_s, rs1_s, rs2_s;
    logic [2:0]    f3_s;
    logic [6:0]    f7_s;
    logic [31:0]   rs1_val_s, rs2_val_s;
    logic [31:0]   imm_i_s, imm_s_s, imm_u_s;
    logic [31:0]   mem_a_s;
    logic [AW-1:0] ma0_s, ma1_s, ma2_s, ma3_s;
    logic [7:0]    lb0_s, lb1_s, lb2_s, lb3_s;
    logic          legal_s;
    logic          wb_en_s;
    logic [31:0]   wb_val_s;
    logic          st_en_s;
    logic          unused_s;

    function automatic logic [31:0] alu_f(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'd0:    r = alt ? (a - b) : (a + b);
            3'd1:    r = a << b[4:0];
            3'd2:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    r = (a < b) ? 32'd1 : 32'd0;
            3'd4:    r = a ^ b;
            3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            3'd6:    r = a | b;
            3'd7:    r = a & b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign bus.data_out      = data_out_r;
    assign bus.cmd_done      = cmd_done_r;
    assign bus.data_out_data = data_out_data_r;
    assign bus.cmd_done_data = cmd_done_data_r;

    // Commands fire only on the rising edge of each valid line.
    assign imem_acc_s = bus.cmd_valid & ~cmd_valid_q_r;
    assign dmem_acc_s = bus.cmd_valid_data & ~cmd_valid_data_q_r;

    // Big-endian instruction word at PC, byte addresses wrapping within the memory.
    always_comb begin
        pa0_s        = pc_r[AW-1:0];
        pa1_s        = pa0_s + AW'(32'd1);
        pa2_s        = pa0_s + AW'(32'd2);
        pa3_s        = pa0_s + AW'(32'd3);
        fetch_word_s = {imem_r[pa0_s], imem_r[pa1_s], imem_r[pa2_s], imem_r[pa3_s]};
    end

    // Decode and execute the held instruction; results are committed in EXEC.
    always_comb begin
        opcode_s  = ir_r[6:0];
        rd_s      = ir_r[11:7];
        f3_s      = ir_r[14:12];
        rs1_s     = ir_r[19:15];
        rs2_s     = ir_r[24:20];
        f7_s      = ir_r[31:25];
        rs1_val_s = regs_r[rs1_s];
        rs2_val_s = regs_r[rs2_s];
        imm_i_s   = {{20{ir_r[31]}}, ir_r[31:20]};
        imm_s_s   = {{20{ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
        imm_u_s   = {ir_r[31:12], 12'd0};
        mem_a_s   = rs1_val_s + ((opcode_s == OPC_STORE) ? imm_s_s : imm_i_s);
        ma0_s     = mem_a_s[AW-1:0];
        ma1_s     = ma0_s + AW'(32'd1);
        ma2_s     = ma0_s + AW'(32'd2);
        ma3_s     = ma0_s + AW'(32'd3);
        lb0_s     = dmem_r[ma0_s];
        lb1_s     = dmem_r[ma1_s];
        lb2_s     = dmem_r[ma2_s];
        lb3_s     = dmem_r[ma3_s];
        legal_s   = 1'b0;
        wb_en_s   = 1'b0;
        wb_val_s  = 32'd0;
        st_en_s   = 1'b0;
        case (opcode_s)
            OPC_OPIMM: begin
                if (f3_s == 3'd1) begin
                    legal_s = (f7_s == 7'h00);
                end else if (f3_s == 3'd5) begin
                    legal_s = (f7_s == 7'h00) || (f7_s == 7'h20);
                end else begin
                    legal_s = 1'b1;
                end
                wb_en_s  = legal_s;
                wb_val_s = alu_f(f3_s, (f3_s == 3'd5) && ir_r[30], rs1_val_s, imm_i_s);
            end
            OPC_OP: begin
                legal_s  = (f7_s == 7'h00) ||
                           ((f7_s == 7'h20) && ((f3_s == 3'd0) || (f3_s == 3'd5)));
                wb_en_s  = legal_s;
                wb_val_s = alu_f(f3_s, ir_r[30], rs1_val_s, rs2_val_s);
            end
            OPC_LUI: begin
                legal_s  = 1'b1;
                wb_en_s  = 1'b1;
                wb_val_s = imm_u_s;
            end
            OPC_AUIPC: begin
                legal_s  = 1'b1;
                wb_en_s  = 1'b1;
                wb_val_s = pc_r + imm_u_s;
            end
            OPC_LOAD: begin
                legal_s = 1'b1;
                wb_en_s = 1'b1;
                case (f3_s)
                    3'd0:    wb_val_s = {{24{lb0_s[7]}}, lb0_s};
                    3'd1:    wb_val_s = {{16{lb0_s[7]}}, lb0_s, lb1_s};
                    3'd2:    wb_val_s = {lb0_s, lb1_s, lb2_s, lb3_s};
                    3'd4:    wb_val_s = {24'd0, lb0_s};
                    3'd5:    wb_val_s = {16'd0, lb0_s, lb1_s};
                    default: begin
                        legal_s  = 1'b0;
                        wb_en_s  = 1'b0;
                        wb_val_s = 32'd0;
                    end
                endcase
            end
            OPC_STORE: begin
                legal_s = (f3_s == 3'd0) || (f3_s == 3'd1) || (f3_s == 3'd2);
                st_en_s = legal_s;
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
    end

    assign unused_s = ^{bus.address[7:AW], bus.address_data[7:AW], mem_a_s[31:AW]};

    // Core FSM, register file, memories and both host ports; the host write is last so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                imem_r[i] <= 8'd0;
                dmem_r[i] <= 8'd0;
            end
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
            pc_r               <= 32'd0;
            ir_r               <= 32'd0;
            state_r            <= ST_IDLE;
            cmd_valid_q_r      <= 1'b0;
            cmd_valid_data_q_r <= 1'b0;
            data_out_r         <= 8'd0;
            cmd_done_r         <= 1'b0;
            data_out_data_r    <= 8'd0;
            cmd_done_data_r    <= 1'b0;
        end else begin
            cmd_valid_q_r      <= bus.cmd_valid;
            cmd_valid_data_q_r <= bus.cmd_valid_data;
            cmd_done_r         <= imem_acc_s;
            cmd_done_data_r    <= dmem_acc_s;

            if (!bus.start_signal) begin
                state_r <= ST_IDLE;
                pc_r    <= 32'd0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        pc_r    <= 32'd0;
                        state_r <= ST_FETCH;
                    end
                    ST_FETCH: begin
                        if (pc_r >= 32'(MEM_BYTES)) begin
                            state_r <= ST_HALT;
                        end else begin
                            ir_r    <= fetch_word_s;
                            state_r <= ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        // An all-zero word decodes as an unsupported opcode, so it halts here too.
                        if (!legal_s) begin
                            state_r <= ST_HALT;
                        end else begin
                            if (wb_en_s && (rd_s != 5'd0)) begin
                                regs_r[rd_s] <= wb_val_s;
                            end
                            if (st_en_s) begin
                                case (f3_s)
                                    3'd0: dmem_r[ma0_s] <= rs2_val_s[7:0];
                                    3'd1: begin
                                        dmem_r[ma0_s] <= rs2_val_s[15:8];
                                        dmem_r[ma1_s] <= rs2_val_s[7:0];
                                    end
                                    3'd2: begin
                                        dmem_r[ma0_s] <= rs2_val_s[31:24];
                                        dmem_r[ma1_s] <= rs2_val_s[23:16];
                                        dmem_r[ma2_s] <= rs2_val_s[15:8];
                                        dmem_r[ma3_s] <= rs2_val_s[7:0];
                                    end
                                    default: dmem_r[ma0_s] <= dmem_r[ma0_s];
                                endcase
                            end
                            pc_r    <= pc_r + 32'd4;
                            state_r <= ST_FETCH;
                        end
                    end
                    ST_HALT: begin
                        state_r <= ST_HALT;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end

            if (imem_acc_s) begin
                if (bus.cmd == 8'd2) begin
                    imem_r[bus.address[AW-1:0]] <= bus.data_in;
                end else if (bus.cmd == 8'd1) begin
                    data_out_r <= imem_r[bus.address[AW-1:0]];
                end else begin
                    data_out_r <= data_out_r;
                end
            end

            if (dmem_acc_s) begin
                if (bus.cmd_data == 8'd2) begin
                    dmem_r[bus.address_data[AW-1:0]] <= bus.data_in_data;
                end else if (bus.cmd_data == 8'd1) begin
                    data_out_data_r <= dmem_r[bus.address_data[AW-1:0]];
`ifdef SIM1_REGREAD_EN
                end else if (bus.cmd_data == 8'd3) begin
                    data_out_data_r <= regs_r[bus.address_data[4:0]][7:0];
`endif
                end else begin
                    data_out_data_r <= data_out_data_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_simulate1_wrapper.sv
// Self-checking bench for simulate1_wrapper: host port protocol, program run, halt, restart and reset.
module tb_simulate1_wrapper;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [7:0] exp_q [$];

    simulate1_wrapper_if bus ();

    simulate1_wrapper #(.MEM_BYTES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] prog [0:11] = '{
        32'h00500113, 32'h00632193, 32'h0031F213, 32'h00005297,
        32'h0072C313, 32'h00235393, 32'h4023D413, 32'h0083A433,
        32'h007111A3, 32'h00710223, 32'h00311483, 32'h00410503
    };

    // One host command: valid held for 'hold' cycles, done pulses counted over a bounded window.
    task automatic host_xfer(input bit dport, input logic [7:0] c, input logic [7:0] a,
                             input logic [7:0] d, input int hold,
                             output logic [7:0] q, output int pulses);
        pulses = 0;
        q = 8'h00;
        @(negedge clk);
        if (dport) begin
            bus.cmd_data = c; bus.address_data = a; bus.data_in_data = d; bus.cmd_valid_data = 1'b1;
        end else begin
            bus.cmd = c; bus.address = a; bus.data_in = d; bus.cmd_valid = 1'b1;
        end
        for (int i = 0; i < hold + 4; i++) begin
            @(negedge clk);
            if (dport && bus.cmd_done_data === 1'b1) begin
                pulses++;
                q = bus.data_out_data;
            end
            if (!dport && bus.cmd_done === 1'b1) begin
                pulses++;
                q = bus.data_out;
            end
            if (i == hold - 1) begin
                bus.cmd_valid = 1'b0;
                bus.cmd_valid_data = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.cmd = 8'd0; bus.cmd_valid = 1'b0; bus.address = 8'd0; bus.data_in = 8'd0;
        bus.cmd_data = 8'd0; bus.cmd_valid_data = 1'b0; bus.address_data = 8'd0; bus.data_in_data = 8'd0;
        bus.start_signal = 1'b0;
        repeat (3) @(negedge clk);
        checks += 4;
        if (bus.data_out !== 8'h00) begin failures++; $display("FAIL reset_data_out got=%h exp=00", bus.data_out); end
        if (bus.cmd_done !== 1'b0) begin failures++; $display("FAIL reset_cmd_done got=%b exp=0", bus.cmd_done); end
        if (bus.data_out_data !== 8'h00) begin failures++; $display("FAIL reset_data_out_data got=%h exp=00", bus.data_out_data); end
        if (bus.cmd_done_data !== 1'b0) begin failures++; $display("FAIL reset_cmd_done_data got=%b exp=0", bus.cmd_done_data); end
        rst = 1'b0;
    endtask

    task automatic test_imem_port();
        logic [7:0] q;
        int p;
        host_xfer(1'b0, 8'd2, 8'd5, 8'hA5, 4, q, p);
        checks++;
        if (p !== 1) begin failures++; $display("FAIL imem_write_pulses got=%0d exp=1", p); end
        exp_q.push_back(8'hA5);
        host_xfer(1'b0, 8'd1, 8'd5, 8'h00, 4, q, p);
        checks += 2;
        if (p !== 1) begin failures++; $display("FAIL imem_read_pulses got=%0d exp=1", p); end
        if (q !== exp_q[0]) begin failures++; $display("FAIL imem_read got=%h exp=%h", q, exp_q[0]); end
        void'(exp_q.pop_front());
        // No-op still pulses and leaves data_out alone.
        exp_q.push_back(8'hA5);
        host_xfer(1'b0, 8'd7, 8'd0, 8'h00, 1, q, p);
        checks += 2;
        if (p !== 1) begin failures++; $display("FAIL imem_noop_pulses got=%0d exp=1", p); end
        if (q !== exp_q[0]) begin failures++; $display("FAIL imem_noop_hold got=%h exp=%h", q, exp_q[0]); end
        void'(exp_q.pop_front());
        // Address 69 wraps onto byte 5.
        host_xfer(1'b0, 8'd2, 8'd69, 8'h3C, 1, q, p);
        exp_q.push_back(8'h3C);
        host_xfer(1'b0, 8'd1, 8'd5, 8'h00, 1, q, p);
        checks++;
        if (q !== exp_q[0]) begin failures++; $display("FAIL imem_wrap got=%h exp=%h", q, exp_q[0]); end
        void'(exp_q.pop_front());
        host_xfer(1'b1, 8'd2, 8'd70, 8'h77, 2, q, p);
        exp_q.push_back(8'h77);
        host_xfer(1'b1, 8'd1, 8'd6, 8'h00, 2, q, p);
        checks++;
        if (q !== exp_q[0]) begin failures++; $display("FAIL dmem_wrap got=%h exp=%h", q, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic read_dmem_checks(input string tag);
        logic [7:0] q;
        int p;
        logic [7:0] addrs [0:3] = '{8'd8, 8'd9, 8'd10, 8'd11};
        logic [7:0] vals  [0:3] = '{8'h14, 8'h02, 8'h00, 8'h00};
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(vals[k]);
            host_xfer(1'b1, 8'd1, addrs[k], 8'h00, 1, q, p);
            checks++;
            if (p !== 1 || q !== exp_q[0]) begin
                failures++;
                $display("FAIL %s dmem[%0d] got=%h pulses=%0d exp=%h", tag, addrs[k], q, p, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_program();
        logic [7:0] q;
        int p;
        logic [31:0] w;
        for (int k = 0; k < 12; k++) begin
            w = prog[k];
            for (int j = 0; j < 4; j++) begin
                host_xfer(1'b0, 8'd2, 8'(4 * k + j), w[31 - 8 * j -: 8], 1, q, p);
            end
        end
        @(negedge clk);
        bus.start_signal = 1'b1;
        repeat (40) @(negedge clk);
        read_dmem_checks("program");
    endtask

    task automatic test_regread();
        logic [7:0] q;
        int p;
`ifdef SIM1_REGREAD_EN
        logic [7:0] ridx [0:8] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
        logic [7:0] rval [0:8] = '{8'h05, 8'h01, 8'h01, 8'h0C, 8'h0B, 8'h02, 8'h00, 8'h02, 8'h02};
        for (int k = 0; k < 9; k++) begin
            exp_q.push_back(rval[k]);
            host_xfer(1'b1, 8'd3, ridx[k], 8'h00, 1, q, p);
            checks++;
            if (q !== exp_q[0]) begin failures++; $display("FAIL regread x%0d got=%h exp=%h", ridx[k], q, exp_q[0]); end
            void'(exp_q.pop_front());
        end
`else
        exp_q.push_back(8'h14);
        host_xfer(1'b1, 8'd1, 8'd8, 8'h00, 1, q, p);
        host_xfer(1'b1, 8'd3, 8'd2, 8'h00, 1, q, p);
        checks += 2;
        if (p !== 1) begin failures++; $display("FAIL regread_noop_pulses got=%0d exp=1", p); end
        if (q !== exp_q[0]) begin failures++; $display("FAIL regread_noop_hold got=%h exp=%h", q, exp_q[0]); end
        void'(exp_q.pop_front());
`endif
    endtask

    task automatic test_halt();
        repeat (100) @(negedge clk);
        read_dmem_checks("halt");
    endtask

    task automatic test_restart();
        logic [7:0] q;
        int p;
        @(negedge clk);
        bus.start_signal = 1'b0;
        host_xfer(1'b1, 8'd2, 8'd8, 8'h00, 1, q, p);
        host_xfer(1'b1, 8'd2, 8'd9, 8'h00, 1, q, p);
        @(negedge clk);
        bus.start_signal = 1'b1;
        repeat (40) @(negedge clk);
        read_dmem_checks("restart");
    endtask

    task automatic test_reset_midrun();
        logic [7:0] q;
        int p;
        host_xfer(1'b0, 8'd1, 8'd0, 8'h00, 1, q, p);
        host_xfer(1'b1, 8'd1, 8'd8, 8'h00, 1, q, p);
        bus.start_signal = 1'b0;
        @(negedge clk);
        bus.start_signal = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks += 4;
        if (bus.data_out !== 8'h00) begin failures++; $display("FAIL midrst_data_out got=%h exp=00", bus.data_out); end
        if (bus.cmd_done !== 1'b0) begin failures++; $display("FAIL midrst_cmd_done got=%b exp=0", bus.cmd_done); end
        if (bus.data_out_data !== 8'h00) begin failures++; $display("FAIL midrst_data_out_data got=%h exp=00", bus.data_out_data); end
        if (bus.cmd_done_data !== 1'b0) begin failures++; $display("FAIL midrst_cmd_done_data got=%b exp=0", bus.cmd_done_data); end
        rst = 1'b0;
        bus.start_signal = 1'b0;
        exp_q.push_back(8'h00);
        host_xfer(1'b1, 8'd1, 8'd8, 8'h00, 1, q, p);
        checks++;
        if (p !== 1 || q !== exp_q[0]) begin failures++; $display("FAIL midrst_dmem8 got=%h pulses=%0d exp=%h", q, p, exp_q[0]); end
        void'(exp_q.pop_front());
        exp_q.push_back(8'h00);
        host_xfer(1'b0, 8'd1, 8'd3, 8'h00, 1, q, p);
        checks++;
        if (p !== 1 || q !== exp_q[0]) begin failures++; $display("FAIL midrst_imem3 got=%h pulses=%0d exp=%h", q, p, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_imem_port();
        test_program();
        test_regread();
        test_halt();
        test_restart();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
